// File: rtl/fir_bench_pkg.sv
// Shared encodings for the FIR stimulus harness: waveform modes, FSM states,
// and the feedback taps used by the stimulus LFSR and the response MISR.
package fir_bench_pkg;

    localparam logic [1:0] MODE_LFSR    = 2'd0;
    localparam logic [1:0] MODE_IMPULSE = 2'd1;
    localparam logic [1:0] MODE_STEP    = 2'd2;
    localparam logic [1:0] MODE_RAMP    = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // MISR feedback from bits 31, 21, 1 and 0
    localparam logic [31:0] MISR_TAPS = 32'h8020_0003;
    localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;

    // x^16+x^14+x^13+x^11+1 as a Fibonacci tap mask on bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return {state[14:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/misr32.sv
// 32-bit multiple-input signature register; each enabled cycle shifts in the
// feedback bit and XORs in the sign-extended (or truncated) input word.
module misr32 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [31:0]      signature
);
    import fir_bench_pkg::*;

    logic [31:0] folded;

    generate
        if (WIDTH < 32) begin : g_sign_extend
            assign folded = {{(32 - WIDTH){data[WIDTH-1]}}, data};
        end else begin : g_truncate
            assign folded = data[31:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature <= MISR_INIT;
        end else if (clear) begin
            signature <= MISR_INIT;
        end else if (enable) begin
            signature <= {signature[30:0], ^(signature & MISR_TAPS)} ^ folded;
        end
    end

endmodule

// File: rtl/fir_stim_harness.sv
// Stimulus-and-capture harness for the FIR datapath: streams NSAMP samples of a
// selectable waveform, folds responses into a MISR and peak register, flags done/timeout.
module fir_stim_harness #(
    parameter int          WIDTH   = 16,
    parameter int          NSAMP   = 256,
    parameter int          TIMEOUT = 1024,
    parameter int          HB_BITS = 24,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             start,
    output logic [WIDTH-1:0] stim_data,
    output logic             stim_valid,
    input  logic             stim_ready,
    input  logic [WIDTH-1:0] resp_data,
    input  logic             resp_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      signature,
    output logic [WIDTH-1:0] peak,
    output logic             led
);
    import fir_bench_pkg::*;

    localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [15:0]      LAST_IDX  = 16'(NSAMP - 1);
    localparam logic [15:0]      NSAMP_W   = 16'(NSAMP);
    localparam logic [31:0]      TIMEOUT_W = 32'(TIMEOUT);

    logic [1:0]         state;
    logic [1:0]         mode_q;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_next;
    logic [15:0]        sample_cnt;
    logic [15:0]        sample_cnt_next;
    logic [15:0]        resp_cnt;
    logic [15:0]        resp_cnt_next;
    logic [31:0]        drain_timer;
    logic [31:0]        drain_timer_next;
    logic [HB_BITS-1:0] hb;
    logic [WIDTH-1:0]   resp_abs;
    logic               start_run;
    logic               beat;
    logic               last_beat;
    logic               resp_take;

    // Top WIDTH bits of the LFSR, zero-padded below when WIDTH exceeds 16
    function automatic logic [WIDTH-1:0] lfsr_to_sample(input logic [15:0] s);
        logic [WIDTH+15:0] wide;
        wide = {s, {WIDTH{1'b0}}};
        return wide[WIDTH+15 -: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] wave_sample(input logic [1:0]  m,
                                                     input logic [15:0] s,
                                                     input logic [15:0] idx);
        logic [WIDTH-1:0] result;
        result = '0;
        case (m)
            MODE_LFSR:    result = lfsr_to_sample(s);
            MODE_IMPULSE: result = (idx == 16'd0) ? MAX_POS : '0;
            MODE_STEP:    result = MAX_POS;
            default:      result = WIDTH'(idx);
        endcase
        return result;
    endfunction

    assign busy             = (state == ST_RUN) || (state == ST_DRAIN);
    assign done             = (state == ST_DONE);
    assign start_run        = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign beat             = stim_valid && stim_ready;
    assign last_beat        = beat && (sample_cnt == LAST_IDX);
    assign resp_take        = resp_valid && busy;
    assign lfsr_next        = lfsr_step(lfsr);
    assign sample_cnt_next  = sample_cnt + 16'd1;
    assign resp_cnt_next    = resp_cnt + 16'(resp_take);
    assign drain_timer_next = drain_timer + 32'd1;

    // The most negative response has no positive twin, so it saturates
    always_comb begin
        resp_abs = resp_data;
        if (resp_data == MOST_NEG) begin
            resp_abs = MAX_POS;
        end else if (resp_data[WIDTH-1]) begin
            resp_abs = -resp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_LFSR;
            lfsr        <= SEED;
            sample_cnt  <= '0;
            resp_cnt    <= '0;
            drain_timer <= '0;
            stim_valid  <= 1'b0;
            stim_data   <= '0;
            peak        <= '0;
            err         <= 1'b0;
        end else if (start_run) begin
            state       <= ST_RUN;
            mode_q      <= mode;
            lfsr        <= SEED;
            sample_cnt  <= '0;
            resp_cnt    <= '0;
            drain_timer <= '0;
            stim_valid  <= 1'b1;
            stim_data   <= wave_sample(mode, SEED, 16'd0);
            peak        <= '0;
            err         <= 1'b0;
        end else begin
            if (resp_take) begin
                resp_cnt <= resp_cnt_next;
                if (resp_abs > peak) begin
                    peak <= resp_abs;
                end
            end
            case (state)
                ST_RUN: begin
                    if (beat) begin
                        lfsr       <= lfsr_next;
                        sample_cnt <= sample_cnt_next;
                        stim_data  <= wave_sample(mode_q, lfsr_next, sample_cnt_next);
                    end
                    if (last_beat) begin
                        stim_valid <= 1'b0;
                        state      <= ST_DRAIN;
                    end
                end
                // A full response count on the same cycle as the timeout still counts as success
                ST_DRAIN: begin
                    drain_timer <= drain_timer_next;
                    if (resp_cnt_next >= NSAMP_W) begin
                        state <= ST_DONE;
                        err   <= 1'b0;
                    end else if (drain_timer_next >= TIMEOUT_W) begin
                        state <= ST_DONE;
                        err   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb <= '0;
        end else begin
            hb <= hb + 1'b1;
        end
    end

    misr32 #(.WIDTH(WIDTH)) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_run),
        .enable    (resp_take),
        .data      (resp_data),
        .signature (signature)
    );

    always_comb begin
        led = 1'b0;
        if (busy) begin
            led = hb[HB_BITS-1];
        end else if (done) begin
            led = err ? hb[HB_BITS-3] : 1'b1;
        end
    end

endmodule
